// File: rtl/simplex_proj_arbiter.sv
// Round-robin front end that shares one simplex-projection pipeline between NUM_REQ check-node
// units, with credit-limited issue and a registered result stage steered back by requester ID.
module simplex_proj_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WIDTH     = $clog2(NUM_REQ),
    parameter int unsigned TAG_WIDTH    = 16,
    parameter int unsigned BLOCKLENGTH  = 6,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned OCC_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]              req_tag,
    input  logic [NUM_REQ*BLOCKLENGTH*DATA_WIDTH-1:0] req_data,
    output logic                                      pipe_valid,
    input  logic                                      pipe_ready,
    output logic [ID_WIDTH+TAG_WIDTH-1:0]             pipe_tag,
    output logic [BLOCKLENGTH*DATA_WIDTH-1:0]         pipe_data,
    input  logic                                      res_valid,
    output logic                                      res_ready,
    input  logic [ID_WIDTH+TAG_WIDTH-1:0]             res_tag,
    input  logic [BLOCKLENGTH*DATA_WIDTH-1:0]         res_data,
    input  logic                                      pipe_busy,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    input  logic [NUM_REQ-1:0]                        rsp_ready,
    output logic [TAG_WIDTH-1:0]                      rsp_tag,
    output logic [BLOCKLENGTH*DATA_WIDTH-1:0]         rsp_data,
    output logic [OCC_WIDTH-1:0]                      occupancy,
    output logic                                      idle,
    output logic                                      err
);

    localparam int unsigned VecW  = BLOCKLENGTH * DATA_WIDTH;
    localparam int unsigned PtagW = ID_WIDTH + TAG_WIDTH;
    localparam logic [OCC_WIDTH-1:0] OccMax = OCC_WIDTH'(MAX_INFLIGHT);

    // Issue register
    logic                 iss_full_q;
    logic [PtagW-1:0]     iss_tag_q;
    logic [VecW-1:0]      iss_data_q;

    // Output register
    logic                 out_full_q;
    logic [ID_WIDTH-1:0]  out_id_q;
    logic [TAG_WIDTH-1:0] out_tag_q;
    logic [VecW-1:0]      out_data_q;

    logic [ID_WIDTH-1:0]  ptr_q;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 err_q;

    logic                 win_found;
    logic [ID_WIDTH-1:0]  win_id;
    logic [TAG_WIDTH-1:0] win_tag;
    logic [VecW-1:0]      win_data;

    logic can_load, accept, pipe_fire;
    logic out_fire, res_fire, res_bad, res_load, res_drop;
    logic bad_id, nothing_inflight;
    logic [ID_WIDTH-1:0] res_id;

    function automatic int unsigned rr_idx(input logic [ID_WIDTH-1:0] base, input int unsigned k);
        return (32'(base) + k) % NUM_REQ;
    endfunction

    // Search ptr+1, ptr+2, ... so the last winner has lowest priority next time.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_tag   = '0;
        win_data  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[i] && (rr_idx(ptr_q, k) == i)) begin
                    win_found = 1'b1;
                    win_id    = ID_WIDTH'(i);
                    win_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                    win_data  = req_data[i*VecW +: VecW];
                end
            end
        end
    end

    assign pipe_fire = iss_full_q & pipe_ready;
    assign can_load  = reset & (~iss_full_q | pipe_ready) & (occ_q < OccMax);
    assign accept    = can_load & win_found;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (32'(win_id) == i);
        end
    end

    assign pipe_valid = iss_full_q;
    assign pipe_tag   = iss_tag_q;
    assign pipe_data  = iss_data_q;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = out_full_q && (32'(out_id_q) == i);
        end
    end

    assign out_fire  = |(rsp_valid & rsp_ready);
    assign res_ready = reset & (~out_full_q | out_fire);
    assign res_fire  = res_valid & res_ready;

    // Results with an impossible ID, or arriving with nothing past the issue register, are dropped.
    assign res_id           = res_tag[PtagW-1 -: ID_WIDTH];
    assign bad_id           = 32'(res_id) >= NUM_REQ;
    assign nothing_inflight = (occ_q == OCC_WIDTH'(iss_full_q));
    assign res_bad          = bad_id | nothing_inflight;
    assign res_load         = res_fire & ~res_bad;
    assign res_drop         = res_fire & res_bad;

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, out_fire})
            2'b10:   if (occ_q < OccMax) occ_d = occ_q + 1'b1;
            2'b01:   if (occ_q != '0) occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_full_q <= 1'b0;
            iss_tag_q  <= '0;
            iss_data_q <= '0;
            out_full_q <= 1'b0;
            out_id_q   <= '0;
            out_tag_q  <= '0;
            out_data_q <= '0;
            ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
            occ_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                iss_full_q <= 1'b1;
                iss_tag_q  <= {win_id, win_tag};
                iss_data_q <= win_data;
                ptr_q      <= win_id;
            end else if (pipe_fire) begin
                iss_full_q <= 1'b0;
            end

            if (res_load) begin
                out_full_q <= 1'b1;
                out_id_q   <= res_id;
                out_tag_q  <= res_tag[TAG_WIDTH-1:0];
                out_data_q <= res_data;
            end else if (out_fire) begin
                out_full_q <= 1'b0;
            end

            if (res_drop) begin
                err_q <= 1'b1;
            end

            occ_q <= occ_d;
        end
    end

    assign rsp_tag   = out_tag_q;
    assign rsp_data  = out_data_q;
    assign occupancy = occ_q;
    assign err       = err_q;
    assign idle      = (occ_q == '0) & ~iss_full_q & ~out_full_q & ~pipe_busy;

endmodule
